// File: rtl/uncache_mem_resp_pkg.sv
// +--------------------------------------------------------------------+
// | uncache_mem_pkg : size encodings, FSM states, size-to-mask helper   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package uncache_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uncache_mem_resp_if.sv
// +--------------------------------------------------------------------+
// | uncache_mem_resp_if : LSU uncached request/response channel         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

interface uncache_mem_resp_if;
  logic        uncache_mem_vld_i;
  logic        uncache_mem_ready_o;
  logic        uncache_mem_write_i;
  logic [2:0]  uncache_mem_size_i;
  logic [63:0] uncache_mem_addr_i;
  logic [63:0] uncache_mem_wdata_i;
  logic        uncache_mem_resp_vld_o;
  logic        uncache_mem_resp_rdy_i;
  logic [63:0] uncache_mem_resp_data_o;

  modport master (
    output uncache_mem_vld_i, uncache_mem_write_i, uncache_mem_size_i,
           uncache_mem_addr_i, uncache_mem_wdata_i, uncache_mem_resp_rdy_i,
    input  uncache_mem_ready_o, uncache_mem_resp_vld_o, uncache_mem_resp_data_o
  );

  modport slave (
    input  uncache_mem_vld_i, uncache_mem_write_i, uncache_mem_size_i,
           uncache_mem_addr_i, uncache_mem_wdata_i, uncache_mem_resp_rdy_i,
    output uncache_mem_ready_o, uncache_mem_resp_vld_o, uncache_mem_resp_data_o
  );
endinterface

`default_nettype wire

// File: rtl/uncache_mem_resp_lane_align.sv
// +--------------------------------------------------------------------+
// | uncache_lane_align : byte-lane enables, store shift, load extract   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module uncache_lane_align
  import uncache_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic        misaligned_o,
  output logic [63:0] rdata_o
);

  logic [7:0]  mask;
  logic [2:0]  low_bits;
  logic [63:0] rdata_sh;

  always_comb begin
    mask     = size_mask(size_i);
    // Offset bits that must be zero for a naturally aligned access.
    low_bits = 3'((4'd1 << size_i) - 4'd1);
    be_o         = mask << off_i;
    wdata_o      = wdata_i << {off_i, 3'b000};
    misaligned_o = |(off_i & low_bits);
    rdata_sh     = rdata_i >> {off_i, 3'b000};
    rdata_o      = '0;
    for (int i = 0; i < 8; i++) begin
      rdata_o[8*i +: 8] = mask[i] ? rdata_sh[8*i +: 8] : 8'h00;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uncache_mem_resp.sv
// +--------------------------------------------------------------------+
// | uncache_mem_resp : uncached LSU responder backed by a 64-bit SRAM   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module uncache_mem_resp
  import uncache_mem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned SRAM_AW   = 12
)(
  input  logic               clk,
  input  logic               rst,
  uncache_mem_resp_if.slave  mem_if,
  output logic               sram_en_o,
  output logic               sram_we_o,
  output logic [7:0]         sram_be_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [63:0]        sram_wdata_o,
  input  logic [63:0]        sram_rdata_i,
  output logic               err_vld_o,
  output logic [63:0]        err_addr_o
);

  localparam logic [63:0] RANGE_BYTES = 64'd8 << SRAM_AW;

  state_e      state_q, state_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        fault_q, fault_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        err_vld_q, err_vld_d;
  logic [63:0] err_addr_q, err_addr_d;

  logic        req_hs;
  logic [63:0] byte_off;
  logic        in_range;
  logic        req_fault;
  logic [1:0]  lane_size;
  logic [2:0]  lane_off;
  logic [7:0]  lane_be;
  logic [63:0] lane_wdata;
  logic        lane_misaligned;
  logic [63:0] lane_rdata;
  logic        unused_size_bit;

  assign unused_size_bit = mem_if.uncache_mem_size_i[2];

  // The aligner serves the live request in IDLE and the latched load afterwards.
  assign lane_size = (state_q == ST_IDLE) ? mem_if.uncache_mem_size_i[1:0] : size_q;
  assign lane_off  = (state_q == ST_IDLE) ? mem_if.uncache_mem_addr_i[2:0] : off_q;

  uncache_lane_align u_lane_align (
    .size_i       (lane_size),
    .off_i        (lane_off),
    .wdata_i      (mem_if.uncache_mem_wdata_i),
    .rdata_i      (sram_rdata_i),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_misaligned),
    .rdata_o      (lane_rdata)
  );

  always_comb begin
    req_hs    = mem_if.uncache_mem_vld_i && (state_q == ST_IDLE);
    byte_off  = mem_if.uncache_mem_addr_i - BASE_ADDR;
    in_range  = (mem_if.uncache_mem_addr_i >= BASE_ADDR) && (byte_off < RANGE_BYTES);
    req_fault = lane_misaligned || !in_range;
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    fault_d      = fault_q;
    resp_data_d  = resp_data_q;
    err_vld_d    = 1'b0;
    err_addr_d   = err_addr_q;
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = 8'h00;
    sram_addr_o  = '0;
    sram_wdata_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          if (req_fault) begin
            err_vld_d  = 1'b1;
            err_addr_d = mem_if.uncache_mem_addr_i;
          end
          if (mem_if.uncache_mem_write_i) begin
            if (!req_fault) begin
              sram_en_o    = 1'b1;
              sram_we_o    = 1'b1;
              sram_be_o    = lane_be;
              sram_addr_o  = byte_off[SRAM_AW+2:3];
              sram_wdata_o = lane_wdata;
            end
          end else begin
            if (!req_fault) begin
              sram_en_o   = 1'b1;
              sram_addr_o = byte_off[SRAM_AW+2:3];
            end
            off_d   = mem_if.uncache_mem_addr_i[2:0];
            size_d  = mem_if.uncache_mem_size_i[1:0];
            fault_d = req_fault;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        resp_data_d = fault_q ? 64'h0 : lane_rdata;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (mem_if.uncache_mem_resp_rdy_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      off_q       <= 3'd0;
      size_q      <= SZ_B;
      fault_q     <= 1'b0;
      resp_data_q <= 64'h0;
      err_vld_q   <= 1'b0;
      err_addr_q  <= 64'h0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      fault_q     <= fault_d;
      resp_data_q <= resp_data_d;
      err_vld_q   <= err_vld_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign mem_if.uncache_mem_ready_o     = (state_q == ST_IDLE);
  assign mem_if.uncache_mem_resp_vld_o  = (state_q == ST_RESP);
  assign mem_if.uncache_mem_resp_data_o = resp_data_q;
  assign err_vld_o                      = err_vld_q;
  assign err_addr_o                     = err_addr_q;

endmodule

`default_nettype wire
